// File: rtl/accumulator_datapath.sv
// accumulator_datapath: program counter, instruction register, general
// register, accumulator, ALU and zero/carry flags driven by the strobes of
// controller_fsm. All outputs come straight from registers.
//
// Strobe semantics: there is no valid/ready handshake. Every strobe is
// level-sampled on each rising clock edge while CLB is low, and the
// controller holds a strobe high for exactly the cycles it wants applied.
// CLB clears all state asynchronously and masks every strobe while high.
module accumulator_datapath #(
    parameter int DW = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          LoadIR,
    input  logic          IncPC,
    input  logic          selPC,
    input  logic          LoadPC,
    input  logic          LoadReg,
    input  logic          LoadAcc,
    input  logic [1:0]    SelAcc,
    input  logic [3:0]    SelALU,
    input  logic [7:0]    imem_data,
    output logic [AW-1:0] pc_addr,
    output logic [7:0]    I,
    output logic          zout,
    output logic          cout,
    output logic [DW-1:0] acc_out,
    output logic [DW-1:0] reg_out
);

    // Width of the immediate slice that fits into the datapath.
    localparam int IMM_W = (DW < 4) ? DW : 4;

    logic [AW-1:0] pc;
    logic [7:0]    ir;
    logic [DW-1:0] acc;
    logic [DW-1:0] gen_reg;
    logic          z_flag;
    logic          c_flag;

    // Immediate field as data (zero-extended / truncated) and as a PC offset
    // (sign-extended for relative jumps).
    logic [DW-1:0] imm_data;
    logic [AW-1:0] imm_abs;
    logic [AW-1:0] imm_rel;

    assign imm_data = DW'(ir[4 +: IMM_W]);
    assign imm_abs  = AW'(ir[7:4]);
    assign imm_rel  = AW'(signed'(ir[7:4]));

    // One extra bit on add/subtract exposes carry-out and borrow directly.
    logic [DW:0] sum_w;
    logic [DW:0] diff_w;

    assign sum_w  = {1'b0, acc} + {1'b0, gen_reg};
    assign diff_w = {1'b0, acc} - {1'b0, gen_reg};

    logic [DW-1:0] alu_y;
    logic          alu_c;
    logic [DW-1:0] acc_next;

    // ALU: operand A is ACC, operand B is REG; unused codes pass A through.
    always_comb begin
        alu_y = acc;
        alu_c = 1'b0;
        case (SelALU)
            4'b0001: begin
                alu_y = sum_w[DW-1:0];
                alu_c = sum_w[DW];
            end
            4'b0010: begin
                alu_y = diff_w[DW-1:0];
                alu_c = diff_w[DW];
            end
            4'b0011: alu_y = acc & gen_reg;
            4'b0100: alu_y = acc | gen_reg;
            4'b0101: alu_y = acc ^ gen_reg;
            4'b0110: alu_y = ~acc;
            default: begin
                alu_y = acc;
                alu_c = 1'b0;
            end
        endcase
    end

    // Accumulator source select.
    always_comb begin
        acc_next = acc;
        case (SelAcc)
            2'b00:   acc_next = gen_reg;
            2'b01:   acc_next = alu_y;
            2'b10:   acc_next = imm_data;
            default: acc_next = acc;
        endcase
    end

    // Program counter: jump beats increment; relative jumps wrap mod 2^AW.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            pc <= '0;
        end else if (LoadPC) begin
            pc <= selPC ? (pc + imm_rel) : imm_abs;
        end else if (IncPC) begin
            pc <= pc + AW'(1);
        end
    end

    // Instruction register: captures the byte at the pre-edge PC.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            ir <= '0;
        end else if (LoadIR) begin
            ir <= imem_data;
        end
    end

    // Accumulator.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            acc <= '0;
        end else if (LoadAcc) begin
            acc <= acc_next;
        end
    end

    // General register: always copies the pre-edge ACC.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            gen_reg <= '0;
        end else if (LoadReg) begin
            gen_reg <= acc;
        end
    end

    // Flags track the ACC written at this edge; carry only moves on ALU writes.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            z_flag <= 1'b0;
            c_flag <= 1'b0;
        end else if (LoadAcc) begin
            z_flag <= (acc_next == '0);
            if (SelAcc == 2'b01) begin
                c_flag <= alu_c;
            end
        end
    end

    assign pc_addr = pc;
    assign I       = ir;
    assign zout    = z_flag;
    assign cout    = c_flag;
    assign acc_out = acc;
    assign reg_out = gen_reg;

endmodule
